// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-side round-robin arbiter.
// Burst support in the arbiter is selected with FIFO_WR_ARB_BURST_EN.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_picker.sv
// Combinational cyclic priority search: first set bit of req at or after
// start_idx, wrapping around the N_REQ requesters.
module rr_picker
  import fifo_wr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand [N_REQ];

  // cand[k] is the k-th index visited when searching from start_idx.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, start_idx} + (IDX_W+1)'(gi);
    assign cand[gi] = (sum >= (IDX_W+1)'(N_REQ)) ?
                      IDX_W'(sum - (IDX_W+1)'(N_REQ)) : sum[IDX_W-1:0];
  end

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Define FIFO_WR_ARB_BURST_EN to let a grant persist for up to BURST_LEN words.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_din,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        grant_vld
);

  localparam int IDX_W = clog2_min1(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  logic [DATA_WIDTH-1:0] data_arr [N_REQ];
  logic [IDX_W-1:0]      last_gnt_reg;
  logic [IDX_W-1:0]      start_idx;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  gnt_vld;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  transfer;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready[gi] = transfer && (gnt_idx == IDX_W'(gi));
  end

  assign start_idx = (last_gnt_reg == IDX_W'(N_REQ - 1)) ? '0 : last_gnt_reg + 1'b1;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (req_valid),
    .start_idx (start_idx),
    .found     (pick_found),
    .idx       (pick_idx)
  );

`ifdef FIFO_WR_ARB_BURST_EN
  localparam logic [7:0] BEAT_LAST = 8'(BURST_LEN - 1);

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [7:0]       beat_cnt_reg, beat_cnt_next;

  always_comb begin
    gnt_vld = pick_found;
    gnt_idx = pick_idx;
    if (state_reg == BURST) begin
      gnt_vld = req_valid[owner_reg];
      gnt_idx = owner_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (transfer && BURST_LEN > 1) begin
          state_next    = BURST;
          owner_next    = gnt_idx;
          beat_cnt_next = 8'd1;
        end
      end
      BURST: begin
        // A departed owner frees the port; fifo_full alone just stalls.
        if (!req_valid[owner_reg]) begin
          state_next    = IDLE;
          beat_cnt_next = 8'd0;
        end else if (transfer) begin
          if (beat_cnt_reg == BEAT_LAST) begin
            state_next    = IDLE;
            beat_cnt_next = 8'd0;
          end else begin
            beat_cnt_next = beat_cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      beat_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end
`else
  assign gnt_vld = pick_found;
  assign gnt_idx = pick_idx;
`endif

  // Outputs are forced low combinationally so they drop the moment reset asserts.
  assign transfer   = rst_n && gnt_vld && !fifo_full;
  assign grant_vld  = rst_n && gnt_vld;
  assign grant_id   = rst_n ? gnt_idx : '0;
  assign fifo_wr_en = transfer;
  assign fifo_din   = transfer ? data_arr[gnt_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_reg <= IDX_W'(N_REQ - 1);
    end else if (transfer) begin
      last_gnt_reg <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (4 producers, 8-bit data, BURST_LEN 4).
// Burst-only scenarios are compiled when FIFO_WR_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        grant_vld;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DATA_STD = {8'h40, 8'h30, 8'h20, 8'h10};

  fifo_wr_arbiter #(
    .N_REQ      (4),
    .DATA_WIDTH (8),
    .BURST_LEN  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 4'b0; fifo_full = 1'b0; req_data = DATA_STD;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; fifo_full = 1'b0; req_data = DATA_STD;
    #3;
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b expected 0", fifo_wr_en); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b expected 0000", req_ready); end
    checks++; if (fifo_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h expected 00", fifo_din); end
    checks++; if (grant_vld !== 1'b0) begin errors++; $display("FAIL reset_grant_vld got %b expected 0", grant_vld); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d expected 0", grant_id); end
    $display("reset: wr_en=%b ready=%b din=%h", fifo_wr_en, req_ready, fifo_din);
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk); #1;
    req_data = {8'h40, 8'h30, 8'h20, 8'hAA}; req_valid = 4'b0001;
    #3;
    checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en got %b expected 1", fifo_wr_en); end
    checks++; if (fifo_din !== 8'hAA) begin errors++; $display("FAIL single_din got %h expected aa", fifo_din); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b expected 0001", req_ready); end
    $display("single: wr_en=%b din=%h ready=%b", fifo_wr_en, fifo_din, req_ready);
    @(posedge clk); #1;
    req_valid = 4'b0;
    #3;
    checks++; if (fifo_wr_en !== 1'b0 || fifo_din !== 8'h00) begin errors++; $display("FAIL single_idle got wr_en=%b din=%h expected 0/00", fifo_wr_en, fifo_din); end
    req_data = DATA_STD;
  endtask

  task automatic test_round_robin();
`ifdef FIFO_WR_ARB_BURST_EN
    int exp_id [5] = '{0, 0, 0, 0, 1};
`else
    int exp_id [5] = '{0, 1, 2, 3, 0};
`endif
    logic [3:0] exp_ready;
    logic [7:0] exp_din;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      req_valid = 4'hF;
      #3;
      exp_ready = 4'b0001 << exp_id[k];
      exp_din   = 8'((exp_id[k] + 1) * 16);
      checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== exp_din) begin errors++; $display("FAIL rr_word%0d got wr_en=%b din=%h expected 1/%h", k, fifo_wr_en, fifo_din, exp_din); end
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready%0d got %b expected %b", k, req_ready, exp_ready); end
      $display("rr beat %0d: din=%h ready=%b", k, fifo_din, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b0;
  endtask

  task automatic test_full_hold();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b0110; fifo_full = 1'b1;
      #3;
      checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || fifo_din !== 8'h00) begin errors++; $display("FAIL full_block%0d got wr_en=%b ready=%b din=%h expected 0/0000/00", k, fifo_wr_en, req_ready, fifo_din); end
      checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL full_grant%0d got vld=%b id=%0d expected 1/1", k, grant_vld, grant_id); end
      $display("full cycle %0d: wr_en=%b grant=%0d", k, fifo_wr_en, grant_id);
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    #3;
    checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h20) begin errors++; $display("FAIL full_release got wr_en=%b din=%h expected 1/20", fifo_wr_en, fifo_din); end
    @(posedge clk); #1;
    req_valid = 4'b0100;
`ifdef FIFO_WR_ARB_BURST_EN
    #3;
    checks++; if (grant_vld !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_owner_gone got vld=%b wr_en=%b expected 0/0", grant_vld, fifo_wr_en); end
    @(posedge clk); #1;
`endif
    #3;
    checks++; if (grant_id !== 2'd2 || fifo_din !== 8'h30 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL full_next got id=%0d din=%h wr_en=%b expected 2/30/1", grant_id, fifo_din, fifo_wr_en); end
    $display("full next: grant=%0d din=%h", grant_id, fifo_din);
    @(posedge clk); #1;
    req_valid = 4'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      req_valid = 4'hF;
    end
    #2;
    checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL arst_pre got %b expected 1", fifo_wr_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || fifo_din !== 8'h00 || grant_vld !== 1'b0) begin errors++; $display("FAIL arst_drop got wr_en=%b ready=%b din=%h vld=%b expected all 0", fifo_wr_en, req_ready, fifo_din, grant_vld); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #3;
    checks++; if (grant_id !== 2'd0 || fifo_din !== 8'h10 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL arst_first got id=%0d din=%h wr_en=%b expected 0/10/1", grant_id, fifo_din, fifo_wr_en); end
    $display("async reset: first grant=%0d din=%h", grant_id, fifo_din);
    @(posedge clk); #1;
    req_valid = 4'b0;
  endtask

`ifdef FIFO_WR_ARB_BURST_EN
  task automatic test_burst();
    int exp_id [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b0011;
      #3;
      checks++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'(exp_id[k])) begin errors++; $display("FAIL burst_beat%0d got wr_en=%b id=%0d expected 1/%0d", k, fifo_wr_en, grant_id, exp_id[k]); end
      $display("burst beat %0d: grant=%0d din=%h", k, grant_id, fifo_din);
    end
    @(posedge clk); #1;
    req_valid = 4'b0;
  endtask

  task automatic test_burst_full();
    logic full_seq [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    logic exp_wr [8]   = '{1, 1, 0, 0, 0, 1, 1, 1};
    int   exp_id [8]   = '{0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b0011; fifo_full = full_seq[k];
      #3;
      checks++; if (fifo_wr_en !== exp_wr[k] || grant_id !== 2'(exp_id[k]) || grant_vld !== 1'b1) begin errors++; $display("FAIL bfull_cyc%0d got wr_en=%b id=%0d vld=%b expected %b/%0d/1", k, fifo_wr_en, grant_id, grant_vld, exp_wr[k], exp_id[k]); end
      $display("burst full cycle %0d: full=%b wr_en=%b grant=%0d", k, fifo_full, fifo_wr_en, grant_id);
    end
    @(posedge clk); #1;
    req_valid = 4'b0; fifo_full = 1'b0;
  endtask

  task automatic test_owner_drop();
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'b0101;
    #3;
    checks++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL drop_beat1 got wr_en=%b id=%0d expected 1/0", fifo_wr_en, grant_id); end
    @(posedge clk); #1;
    req_valid = 4'b0100;
    #3;
    checks++; if (grant_vld !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL drop_gap got vld=%b wr_en=%b expected 0/0", grant_vld, fifo_wr_en); end
    @(posedge clk); #1;
    #3;
    checks++; if (grant_id !== 2'd2 || fifo_din !== 8'h30 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL drop_next got id=%0d din=%h wr_en=%b expected 2/30/1", grant_id, fifo_din, fifo_wr_en); end
    $display("owner drop: next grant=%0d din=%h", grant_id, fifo_din);
    @(posedge clk); #1;
    req_valid = 4'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_hold();
    test_async_reset();
`ifdef FIFO_WR_ARB_BURST_EN
    test_burst();
    test_burst_full();
    test_owner_drop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
